// File: rtl/mem_arbiter_if.sv
// Bundle of request-unit and RAM-side signals shared by the memory arbiter.
interface mem_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        ihit;
    logic [31:0] iload;
    logic        dhit;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        err;

    // Arbiter side
    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, err
    );

    // CPU request unit / RAM model side
    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: data accesses win, instruction fetch starvation is
// bounded by a saturating streak counter of back-to-back data grants.
module mem_arbiter #(
    parameter int unsigned DSTREAK_MAX = 4
) (
    input logic          CLK,
    input logic          nRST,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, IACC, DACC} state_t;
    typedef enum logic [1:0] {RAM_FREE, RAM_BUSY, RAM_ACCESS, RAM_ERROR} ramstate_t;

    localparam logic [3:0] STREAK_MAX = 4'(DSTREAK_MAX);

    state_t     state_q, state_d;
    logic [3:0] dstreak_q, dstreak_d;
    logic       err_q, err_d;

    logic d_req;
    assign d_req = bus.dREN | bus.dWEN;

    // Load data is a straight passthrough; hits qualify it
    assign bus.iload = bus.ramload;
    assign bus.dload = bus.ramload;
    assign bus.err   = err_q;

    // State register with asynchronous active-high reset
    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            state_q   <= IDLE;
            dstreak_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            dstreak_q <= dstreak_d;
            err_q     <= err_d;
        end
    end

    // Next-state: arbitration in IDLE, completion/abort/error in an access
    always_comb begin
        state_d   = state_q;
        dstreak_d = dstreak_q;
        err_d     = err_q;
        unique case (state_q)
            IDLE: begin
                if (d_req && !(bus.iREN && dstreak_q == STREAK_MAX)) begin
                    state_d = DACC;
                    if (!bus.iREN)
                        dstreak_d = '0;
                    else if (dstreak_q != STREAK_MAX)
                        dstreak_d = dstreak_q + 4'd1;
                end else if (bus.iREN) begin
                    state_d   = IACC;
                    dstreak_d = '0;
                end
            end
            IACC: begin
                if (bus.ramstate == RAM_ERROR)
                    err_d = 1'b1;
                if (!bus.iREN || bus.ramstate == RAM_ACCESS || bus.ramstate == RAM_ERROR)
                    state_d = IDLE;
            end
            DACC: begin
                if (bus.ramstate == RAM_ERROR)
                    err_d = 1'b1;
                if (!d_req || bus.ramstate == RAM_ACCESS || bus.ramstate == RAM_ERROR)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: RAM strobes/address per owner, hit on ACCESS while still requested
    always_comb begin
        bus.ihit     = 1'b0;
        bus.dhit     = 1'b0;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        unique case (state_q)
            IACC: begin
                bus.ramREN  = 1'b1;
                bus.ramaddr = bus.iaddr;
                bus.ihit    = bus.iREN && (bus.ramstate == RAM_ACCESS);
            end
            DACC: begin
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                bus.ramWEN   = bus.dWEN;
                bus.ramREN   = bus.dREN & ~bus.dWEN;
                bus.dhit     = d_req && (bus.ramstate == RAM_ACCESS);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// traffic compared against a cycle-level reference model of the arbiter.
module tb_mem_arbiter;

    localparam int MAXS = 4;

    logic CLK = 1'b0;
    logic nRST;

    mem_arbiter_if bus();

    mem_arbiter #(.DSTREAK_MAX(MAXS)) dut (
        .CLK (CLK),
        .nRST(nRST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the RAM (0 none, 1 fetch, 2 data), how many
    // data grants in a row went past a waiting fetch, and the sticky error.
    int owner_m  = 0;
    int streak_m = 0;
    bit err_m    = 1'b0;

    // Last observed values, for directed expectations
    logic        o_ihit, o_dhit, o_ramREN, o_ramWEN, o_err;
    logic [31:0] o_ramaddr, o_ramstore, o_iload, o_dload;
    logic        prev_hit = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        owner_m  = 0;
        streak_m = 0;
        err_m    = 1'b0;
        prev_hit = 1'b0;
    endtask

    // One clock: compare at negedge against the model, advance model at posedge
    task automatic step();
        logic        e_ihit, e_dhit, e_ren, e_wen, hit_now;
        logic [31:0] e_addr, e_store;
        bit          dw;
        @(negedge CLK);
        dw      = bus.dREN || bus.dWEN;
        e_ihit  = (owner_m == 1) && bus.iREN && (bus.ramstate == 2'd2);
        e_dhit  = (owner_m == 2) && dw && (bus.ramstate == 2'd2);
        e_wen   = (owner_m == 2) && bus.dWEN;
        e_ren   = (owner_m == 1) || ((owner_m == 2) && bus.dREN && !bus.dWEN);
        e_addr  = (owner_m == 1) ? bus.iaddr : (owner_m == 2) ? bus.daddr : 32'h0;
        e_store = (owner_m == 2) ? bus.dstore : 32'h0;
        o_ihit = bus.ihit; o_dhit = bus.dhit; o_ramREN = bus.ramREN; o_ramWEN = bus.ramWEN;
        o_err = bus.err; o_ramaddr = bus.ramaddr; o_ramstore = bus.ramstore;
        o_iload = bus.iload; o_dload = bus.dload;
        chk("ihit", 32'(bus.ihit), 32'(e_ihit));
        chk("dhit", 32'(bus.dhit), 32'(e_dhit));
        chk("ramREN", 32'(bus.ramREN), 32'(e_ren));
        chk("ramWEN", 32'(bus.ramWEN), 32'(e_wen));
        chk("ramaddr", bus.ramaddr, e_addr);
        chk("ramstore", bus.ramstore, e_store);
        chk("err", 32'(bus.err), 32'(err_m));
        chk("iload", bus.iload, bus.ramload);
        chk("dload", bus.dload, bus.ramload);
        chk("hit_excl", 32'(bus.ihit & bus.dhit), 32'h0);
        chk("strobe_excl", 32'(bus.ramREN & bus.ramWEN), 32'h0);
        hit_now = bus.ihit | bus.dhit;
        chk("bubble", 32'(hit_now & prev_hit), 32'h0);
        prev_hit = hit_now;
        @(posedge CLK);
        if (nRST) begin
            model_reset();
        end else if (owner_m == 0) begin
            if (dw && !(bus.iREN && streak_m >= MAXS)) begin
                owner_m  = 2;
                streak_m = bus.iREN ? ((streak_m + 1 > MAXS) ? MAXS : streak_m + 1) : 0;
            end else if (bus.iREN) begin
                owner_m  = 1;
                streak_m = 0;
            end
        end else begin
            if (bus.ramstate == 2'd3) err_m = 1'b1;
            if (!((owner_m == 1) ? bus.iREN : dw) || bus.ramstate == 2'd2 || bus.ramstate == 2'd3)
                owner_m = 0;
        end
        #1;
    endtask

    // Asynchronous reset pulse asserted between edges; outputs must drop at once
    task automatic do_reset();
        #1 nRST = 1'b1;
        #1;
        chk("rst_ramWEN", 32'(bus.ramWEN), 32'h0);
        chk("rst_ramREN", 32'(bus.ramREN), 32'h0);
        chk("rst_dhit", 32'(bus.dhit), 32'h0);
        chk("rst_ihit", 32'(bus.ihit), 32'h0);
        chk("rst_err", 32'(bus.err), 32'h0);
        chk("rst_ramaddr", bus.ramaddr, 32'h0);
        model_reset();
        @(posedge CLK);
        #1 nRST = 1'b0;
    endtask

    task automatic idle_inputs();
        bus.iREN = 1'b0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
        bus.iaddr = '0; bus.daddr = '0; bus.dstore = '0;
        bus.ramload = '0; bus.ramstate = 2'd0;
    endtask

    initial begin
        int dcount;
        int r;
        bit seen;
        nRST = 1'b1;
        idle_inputs();

        // Reset held from time zero
        step();
        step();
        @(posedge CLK);
        #1 nRST = 1'b0;
        step();
        step();

        // Single fetch with zero-wait RAM
        bus.iREN = 1'b1; bus.iaddr = 32'h40; bus.ramload = 32'h8C220004; bus.ramstate = 2'd2;
        step();
        chk("fetch_idle_ren", 32'(o_ramREN), 32'h0);
        step();
        chk("fetch_ren", 32'(o_ramREN), 32'h1);
        chk("fetch_addr", o_ramaddr, 32'h40);
        chk("fetch_ihit", 32'(o_ihit), 32'h1);
        chk("fetch_iload", o_iload, 32'h8C220004);
        bus.iREN = 1'b0;
        step();
        chk("fetch_after_ren", 32'(o_ramREN), 32'h0);

        // Contention: data write wins, fetch follows
        bus.iREN = 1'b1; bus.iaddr = 32'h44; bus.dWEN = 1'b1;
        bus.daddr = 32'h100; bus.dstore = 32'hDEADBEEF;
        step();
        step();
        chk("cont_wen", 32'(o_ramWEN), 32'h1);
        chk("cont_store", o_ramstore, 32'hDEADBEEF);
        chk("cont_addr", o_ramaddr, 32'h100);
        chk("cont_dhit", 32'(o_dhit), 32'h1);
        chk("cont_no_ihit", 32'(o_ihit), 32'h0);
        bus.dWEN = 1'b0;
        step();
        step();
        chk("cont_ihit", 32'(o_ihit), 32'h1);
        chk("cont_iaddr", o_ramaddr, 32'h44);
        bus.iREN = 1'b0;
        step();

        // Wait states on a data read
        bus.dREN = 1'b1; bus.daddr = 32'h200; bus.ramstate = 2'd1;
        step();
        for (int k = 0; k < 3; k++) begin
            step();
            chk("wait_ren", 32'(o_ramREN), 32'h1);
            chk("wait_addr", o_ramaddr, 32'h200);
            chk("wait_no_dhit", 32'(o_dhit), 32'h0);
        end
        bus.ramstate = 2'd2; bus.ramload = 32'h1234;
        step();
        chk("wait_dhit", 32'(o_dhit), 32'h1);
        chk("wait_dload", o_dload, 32'h1234);
        bus.dREN = 1'b0;
        step();

        // Reset mid-DACC with RAM busy
        bus.dWEN = 1'b1; bus.daddr = 32'h300; bus.ramstate = 2'd1;
        step();
        step();
        chk("pre_rst_wen", 32'(o_ramWEN), 32'h1);
        do_reset();
        idle_inputs();
        step();
        step();
        chk("post_rst_wen", 32'(o_ramWEN), 32'h0);

        // Starvation bound: DSTREAK_MAX data grants, then the fetch
        bus.iREN = 1'b1; bus.iaddr = 32'h80; bus.dREN = 1'b1; bus.daddr = 32'h400;
        bus.ramstate = 2'd2;
        for (int round = 0; round < 2; round++) begin
            dcount = 0;
            seen = 1'b0;
            for (int k = 0; k < 40 && !seen; k++) begin
                step();
                if (o_dhit) dcount++;
                if (o_ihit) seen = 1'b1;
            end
            chk("starve_ihit_seen", 32'(seen), 32'h1);
            chk("starve_dgrants", 32'(dcount), 32'(MAXS));
        end
        idle_inputs();
        step();

        // Error during fetch: sticky err, no hit
        bus.iREN = 1'b1; bus.iaddr = 32'h90; bus.ramstate = 2'd3;
        step();
        step();
        chk("errc_no_ihit", 32'(o_ihit), 32'h0);
        bus.iREN = 1'b0; bus.ramstate = 2'd0;
        step();
        chk("errc_err", 32'(o_err), 32'h1);
        chk("errc_idle", 32'(o_ramREN), 32'h0);
        step();
        chk("errc_sticky", 32'(o_err), 32'h1);

        // Abort: data read dropped while RAM busy
        bus.dREN = 1'b1; bus.daddr = 32'h500; bus.ramstate = 2'd1;
        step();
        step();
        bus.dREN = 1'b0;
        step();
        chk("abort_no_dhit", 32'(o_dhit), 32'h0);
        step();
        chk("abort_idle", 32'(o_ramREN), 32'h0);
        chk("abort_err_kept", 32'(o_err), 32'h1);

        // Randomized traffic against the model
        do_reset();
        idle_inputs();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) bus.iREN = ~bus.iREN;
            if ($urandom_range(0, 7) == 0) bus.dREN = ~bus.dREN;
            if ($urandom_range(0, 9) == 0) bus.dWEN = ~bus.dWEN;
            if (o_ihit && $urandom_range(0, 1) == 0) bus.iREN = 1'b0;
            if (o_dhit && $urandom_range(0, 1) == 0) begin bus.dREN = 1'b0; bus.dWEN = 1'b0; end
            bus.iaddr = $urandom; bus.daddr = $urandom; bus.dstore = $urandom;
            bus.ramload = $urandom;
            r = $urandom_range(0, 31);
            bus.ramstate = (r == 0) ? 2'd3 : (r < 8) ? 2'd1 : (r < 11) ? 2'd0 : 2'd2;
            if (i % 150 == 149) do_reset();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-ported RAM between the instruction-fetch path and the data path of the CPU. It sits between the request-unit outputs (imemREN, dmemREN/dmemWEN) and the RAM model.
- Sequences each access through a small FSM and returns ihit/dhit pulses with load data.
- Data accesses have priority. A streak counter bounds how long instruction fetch can be starved.

Parameters:
DSTREAK_MAX, 4, maximum consecutive data grants while iREN is pending before instruction fetch is forced (range 1..15)

Ports:
CLK  input  1  system clock; all state updates on rising edge
nRST  input  1  reset; asynchronous, active-high (1 = reset asserted)
iREN  input  1  instruction read request; held until ihit
iaddr  input  32  instruction address
dREN  input  1  data read request; held until dhit
dWEN  input  1  data write request; held until dhit
daddr  input  32  data address
dstore  input  32  data write value
ihit  output  1  instruction access complete this cycle
iload  output  32  instruction read data; valid only when ihit=1
dhit  output  1  data access complete this cycle
dload  output  32  data read data; valid only when dhit=1 and access was a read
ramREN  output  1  RAM read strobe
ramWEN  output  1  RAM write strobe
ramaddr  output  32  RAM address
ramstore  output  32  RAM write data
ramload  input  32  RAM read data
ramstate  input  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
err  output  1  sticky RAM-error flag

Behaviour:
- State: FSM {IDLE, IACC, DACC}, 4-bit dstreak counter, err flop. nRST=1 forces IDLE, dstreak=0, err=0 immediately, regardless of clock. Reset mid-access drops the access; no hit is issued.
- Reset/IDLE output values: ihit=dhit=0, ramREN=ramWEN=0, ramaddr=0, ramstore=0. iload=dload=ramload always (passthrough).
- IDLE arbitration, evaluated each edge:
  - If (dREN|dWEN) and not (iREN and dstreak==DSTREAK_MAX): go to DACC, and dstreak+=1 if iREN else dstreak=0.
  - Else if iREN: go to IACC, dstreak=0.
  - Else stay in IDLE.
- The first RAM strobe appears the cycle after the request is seen in IDLE (1-cycle grant latency).
- IACC outputs: ramREN=1, ramaddr=iaddr, ramWEN=0.
- DACC outputs: ramaddr=daddr, ramstore=dstore; ramWEN=dWEN, ramREN=dREN & ~dWEN. Write wins if both dREN and dWEN are asserted.
- Completion:
  - In xACC with ramstate==ACCESS and the request still asserted: the matching hit=1 combinationally for that cycle, then next state is IDLE.
  - FREE/BUSY: remain in xACC, strobes held stable.
- Abort: the owning request deasserts while in xACC: return to IDLE next edge, no hit.
- ERROR (ramstate==3) in xACC: err set (sticky until reset), return to IDLE, no hit. The requester re-requests.
- ihit and dhit are never high in the same cycle. At most one strobe (ramREN/ramWEN) is high per cycle.
- Mandatory IDLE bubble between accesses: at most one completed access per 2 cycles even with zero-wait RAM.
- dstreak saturates at DSTREAK_MAX and never wraps.

Test Plan:
- Reset: nRST pulsed mid-DACC with ramstate=BUSY -> same cycle ramWEN=ramREN=0, err=0, no dhit; after release with no requests, outputs stay 0.
- Single fetch, 0-wait RAM: iREN=1, iaddr=0x40, ramload=0x8C220004 -> ramREN=1/ramaddr=0x40 from cycle 1; ramstate=ACCESS in cycle 1 -> ihit=1, iload=0x8C220004 in cycle 1; IDLE in cycle 2.
- Contention: iREN and dWEN asserted together, daddr=0x100, dstore=0xDEADBEEF -> DACC first (ramWEN=1, ramstore=0xDEADBEEF), dhit; IACC follows on the next grant.
- Wait states: dREN, ramstate BUSY for 3 cycles then ACCESS with ramload=0x1234 -> strobes and address stable throughout; dhit=1 and dload=0x1234 exactly on the ACCESS cycle.
- Starvation bound, DSTREAK_MAX=4: iREN held with continuous data requests -> exactly 4 DACC grants, then IACC; dstreak resets to 0.
- Error/abort: ramstate=ERROR in IACC -> err=1 sticky, no ihit, back to IDLE. Separately, dREN dropped during BUSY -> IDLE, no dhit, err unchanged.
